// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with architectural HI/LO registers.
// Iterative shift-add multiply and restoring divide on operand magnitudes,
// with a one-cycle sign-fix stage before HI/LO are committed.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a new op; MTHI/MTLO/MFHI/MFLO complete here
//   MUL   | 32 shift-add iterations on magnitudes (cnt 0..31)
//   DIV   | 32 restoring-division iterations on magnitudes (cnt 0..31)
//   FIX   | apply result signs, commit HI/LO at the end of the cycle
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [7:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [63:0] acc_q, acc_d;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [31:0] m_q, m_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        a_neg_q, a_neg_d;
  logic        divz_q, divz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_onehot;
  logic        accept;
  logic        signed_op;
  logic        a_neg_in, b_neg_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_sub;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign op_onehot = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  assign op_ready  = (state_q == S_IDLE);
  assign busy      = ~op_ready;
  assign accept    = op_valid & op_ready & ~flush & op_onehot;
  assign done      = done_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

  assign signed_op = op[0] | op[2];
  assign a_neg_in  = signed_op & src_a[31];
  assign b_neg_in  = signed_op & src_b[31];
  assign mag_a     = a_neg_in ? (32'd0 - src_a) : src_a;
  assign mag_b     = b_neg_in ? (32'd0 - src_b) : src_b;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, m_q});
  assign div_sub   = div_shift - {1'b0, m_q};

  // A zero divisor leaves the dividend magnitude in the remainder, so the
  // sign-restored remainder already equals the original src_a.
  assign prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
  assign quo_fix   = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix   = a_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  // Zero-latency HI/LO read, only while the read op is actually accepted.
  always_comb begin
    rdata = 32'd0;
    if (accept && op[4]) rdata = hi_q;
    else if (accept && op[5]) rdata = lo_q;
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    a_neg_d   = a_neg_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op[0] || op[1]) begin
            state_d   = S_MUL;
            cnt_d     = 5'd0;
            acc_d     = {32'd0, mag_b};
            m_d       = mag_a;
            is_div_d  = 1'b0;
            neg_res_d = a_neg_in ^ b_neg_in;
            a_neg_d   = a_neg_in;
            divz_d    = 1'b0;
          end else if (op[2] || op[3]) begin
            state_d   = S_DIV;
            cnt_d     = 5'd0;
            acc_d     = {32'd0, mag_a};
            m_d       = mag_b;
            is_div_d  = 1'b1;
            neg_res_d = a_neg_in ^ b_neg_in;
            a_neg_d   = a_neg_in;
            divz_d    = (src_b == 32'd0);
          end else if (op[6]) begin
            hi_d = src_a;
          end else if (op[7]) begin
            lo_d = src_a;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {(div_ge ? div_sub[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = divz_q ? 32'hFFFF_FFFF : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including the FIX-cycle commit.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      m_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      a_neg_q   <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      a_neg_q   <= a_neg_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: op_valid  in  1  EXE stage presents a multiply/divide/HI-LO op.
REQ-004 SHALL have: op  in  8  one-hot op code: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MFHI [5]MFLO [6]MTHI [7]MTLO.
REQ-005 SHALL have: src_a  in  32  rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-006 SHALL have: src_b  in  32  rt operand (divisor or multiplier).
REQ-007 SHALL have: flush  in  1  exception/cancel; aborts any in-flight operation.
REQ-008 SHALL have: op_ready  out  1  op accepted this cycle when op_valid && op_ready.
REQ-009 SHALL have: busy  out  1  iterative operation in flight.
REQ-010 SHALL have: done  out  1  one-cycle pulse on the cycle after HI/LO is committed by MULT/DIV.
REQ-011 SHALL have: rdata  out  32  MFHI/MFLO result.
REQ-012 SHALL have: hi_out, lo_out  out  32 each  architectural HI/LO registers.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX; op_ready=1 only in IDLE; busy=1 in MUL, DIV, FIX.
REQ-014 SHALL accept an op only when op_valid, op_ready, !flush, and op has exactly one bit set; zero-hot or multi-hot op SHALL be ignored with no state change.
REQ-015 MULT/MULTU accepted at edge E SHALL go IDLE->MUL, run 32 shift-add iterations (counter 0..31, one per cycle), then FIX for one cycle.
REQ-016 DIV/DIVU SHALL go IDLE->DIV, run 32 restoring-division iterations, then FIX for one cycle.
REQ-017 Signed ops SHALL iterate on operand magnitudes; FIX SHALL negate the product if signs differ, negate the quotient if signs differ, and give the remainder the sign of the dividend.
REQ-018 HI/LO SHALL be written on edge E+33 (end of FIX): MUL -> HI=product[63:32], LO=product[31:0]; DIV -> LO=quotient, HI=remainder; the state returns to IDLE on the same edge.
REQ-019 done SHALL be 1 for exactly one cycle, the cycle following edge E+33; op_ready SHALL also be 1 in that cycle.
REQ-020 DIV/DIVU with src_b=0 SHALL produce LO=0xFFFFFFFF and HI=src_a, with the same latency.
REQ-021 DIV 0x80000000/0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-022 Operands SHALL be latched on the accept edge; later changes to src_a/src_b SHALL have no effect.
REQ-023 MTHI/MTLO SHALL write src_a to HI/LO on the accept edge, with no busy period.
REQ-024 MFHI/MFLO SHALL be zero-latency: rdata = HI/LO combinationally while op_valid and op_ready; otherwise rdata=0.
REQ-025 flush in any state SHALL force IDLE on the next edge with no HI/LO write and no done pulse; flush concurrent with op_valid SHALL accept nothing.
REQ-026 A flush on the FIX cycle SHALL take priority over the HI/LO commit.

Reset
REQ-027 While rst_n=0 at an edge: state=IDLE, counter=0, HI=LO=0, internal operand/accumulator registers=0.
REQ-028 Output values under reset: op_ready=1, busy=0, done=0, rdata=0, hi_out=lo_out=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no HI/LO write.

Verification
REQ-030 MULT 0xFFFFFFFE x 0x00000003 -> busy for cycles E+1..E+33; HI=0xFFFFFFFF, LO=0xFFFFFFFA at E+33; done pulse in the following cycle.
REQ-031 DIVU 100/7 -> LO=14, HI=2; DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-033 Start MULTU, assert flush at iteration 10 -> IDLE the next cycle, HI/LO unchanged, no done pulse, op_ready=1.
REQ-034 MFHI held while busy -> op_ready=0 until the done cycle, then rdata equals the new HI in that same cycle.
REQ-035 Reset mid-DIV -> all outputs at REQ-028 values; a subsequent MTLO 0x12345678 gives lo_out=0x12345678 on the next edge.
